// File: rtl/fifo_rx_frame.sv
// Receive frame FIFO: bytes are stored speculatively and only become visible to the
// reader once their frame ends good; bad or overflowing frames are rolled back and counted.
module fifo_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  frame_end,
  input  logic                  frame_bad,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out,
  output logic                  data_valid,
  output logic                  full_flag,
  output logic                  empty_flag,
  output logic                  almost_full_flag,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  frame_dropped,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH:0]   mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  last_out_q, last_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_dropped_q, frame_dropped_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic [PW-1:0]         fill;
  logic                  mem_we;
  logic                  drop;
  logic                  rd_fire;
  logic [DATA_WIDTH:0]   rd_word;

  // Fill counts uncommitted bytes too, so a long frame cannot overwrite unread data.
  assign fill             = wr_ptr_q - rd_ptr_q;
  assign full_flag        = (fill == PW'(DEPTH));
  assign empty_flag       = (commit_ptr_q == rd_ptr_q);
  assign almost_full_flag = (fill >= PW'(AF_THRESH));
  assign level            = commit_ptr_q - rd_ptr_q;

  assign data_out      = data_out_q;
  assign last_out      = last_out_q;
  assign data_valid    = data_valid_q;
  assign frame_dropped = frame_dropped_q;
  assign drop_count    = drop_count_q;

  assign rd_fire = read_enable && !empty_flag;
  assign rd_word = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    commit_ptr_d    = commit_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    ovf_d           = ovf_q;
    data_out_d      = data_out_q;
    last_out_d      = last_out_q;
    data_valid_d    = 1'b0;
    frame_dropped_d = 1'b0;
    drop_count_d    = drop_count_q;
    mem_we          = 1'b0;
    drop            = 1'b0;

    if (rd_fire) begin
      data_out_d   = rd_word[DATA_WIDTH-1:0];
      last_out_d   = rd_word[DATA_WIDTH];
      data_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + PW'(1);
    end

    if (write_enable) begin
      if (ovf_q) begin
        // Overflowed frame: swallow bytes until its end, then roll back.
        if (frame_end) begin
          ovf_d = 1'b0;
          drop  = 1'b1;
        end
      end else if (full_flag) begin
        if (frame_end) drop = 1'b1;
        else           ovf_d = 1'b1;
      end else if (frame_end && frame_bad) begin
        drop = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (frame_end) commit_ptr_d = wr_ptr_q + PW'(1);
      end
    end

    if (drop) begin
      wr_ptr_d        = commit_ptr_q;
      frame_dropped_d = 1'b1;
      if (drop_count_q != {CNT_WIDTH{1'b1}}) drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {frame_end, data_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      commit_ptr_q    <= '0;
      rd_ptr_q        <= '0;
      ovf_q           <= 1'b0;
      data_out_q      <= '0;
      last_out_q      <= 1'b0;
      data_valid_q    <= 1'b0;
      frame_dropped_q <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      commit_ptr_q    <= commit_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      ovf_q           <= ovf_d;
      data_out_q      <= data_out_d;
      last_out_q      <= last_out_d;
      data_valid_q    <= data_valid_d;
      frame_dropped_q <= frame_dropped_d;
      drop_count_q    <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_rx_frame.sv
// Bench for fifo_rx_frame: queue-based frame model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_fifo_rx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        write_enable, frame_end, frame_bad, read_enable;
  logic [7:0]  data_out;
  logic        last_out, data_valid, full_flag, empty_flag, almost_full_flag;
  logic [4:0]  level;
  logic        frame_dropped;
  logic [15:0] drop_count;

  fifo_rx_frame #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(12), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .write_enable(write_enable),
    .frame_end(frame_end), .frame_bad(frame_bad), .read_enable(read_enable),
    .data_out(data_out), .last_out(last_out), .data_valid(data_valid),
    .full_flag(full_flag), .empty_flag(empty_flag), .almost_full_flag(almost_full_flag),
    .level(level), .frame_dropped(frame_dropped), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: committed bytes and the in-progress frame kept as queues of {last, data}.
  logic [8:0]  m_com[$];
  logic [8:0]  m_pend[$];
  bit          m_ovf;
  logic [7:0]  m_dout;
  logic        m_last, m_dv, m_drop;
  logic [15:0] m_cnt;

  always @(posedge clk) begin : model
    int   fill;
    bit   mfull, mempty;
    logic [8:0] w;
    if (rst) begin
      m_com.delete(); m_pend.delete();
      m_ovf = 0; m_dout = 8'h00; m_last = 0; m_dv = 0; m_drop = 0; m_cnt = 16'h0;
    end else begin
      fill   = m_com.size() + m_pend.size();
      mfull  = (fill == 16);
      mempty = (m_com.size() == 0);
      m_drop = 0;
      m_dv   = 0;
      if (read_enable && !mempty) begin
        w = m_com.pop_front();
        m_dout = w[7:0]; m_last = w[8]; m_dv = 1;
      end
      if (write_enable) begin
        if (m_ovf) begin
          if (frame_end) begin m_ovf = 0; m_pend.delete(); m_drop = 1; end
        end else if (mfull) begin
          if (frame_end) begin m_pend.delete(); m_drop = 1; end
          else m_ovf = 1;
        end else if (frame_end && frame_bad) begin
          m_pend.delete(); m_drop = 1;
        end else begin
          m_pend.push_back({frame_end, data_in});
          if (frame_end) begin
            foreach (m_pend[i]) m_com.push_back(m_pend[i]);
            m_pend.delete();
          end
        end
      end
      if (m_drop && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  logic [8:0] rx_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("empty_flag", 32'(empty_flag), 32'(m_com.size() == 0));
      check("full_flag", 32'(full_flag), 32'((m_com.size() + m_pend.size()) == 16));
      check("almost_full", 32'(almost_full_flag), 32'((m_com.size() + m_pend.size()) >= 12));
      check("level", 32'(level), 32'(m_com.size()));
      check("data_valid", 32'(data_valid), 32'(m_dv));
      check("data_out", 32'(data_out), 32'(m_dout));
      check("last_out", 32'(last_out), 32'(m_last));
      check("frame_dropped", 32'(frame_dropped), 32'(m_drop));
      check("drop_count", 32'(drop_count), 32'(m_cnt));
      if (data_valid === 1'b1) begin
        rx_q.push_back({last_out, data_out});
        $display("rd data=%02h last=%0b level=%0d", data_out, last_out, level);
      end
    end
  end

  task automatic cyc(input logic we, input logic [7:0] d, input logic fe, input logic fb,
                     input logic re);
    write_enable = we; data_in = d; frame_end = fe; frame_bad = fb; read_enable = re;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    write_enable = 0; data_in = 8'h00; frame_end = 0; frame_bad = 0; read_enable = 0;
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    int k;
    rst = 1'b1;
    write_enable = 0; data_in = 8'h00; frame_end = 0; frame_bad = 0; read_enable = 0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    rst = 1'b0;
    check("rst_empty", 32'(empty_flag), 32'd1);
    check("rst_full", 32'(full_flag), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_cnt", 32'(drop_count), 32'd0);

    // Underflow read and stray frame_end/frame_bad without write_enable are ignored.
    cyc(0, 8'h00, 1, 1, 1);
    check("empty_read_dv", 32'(data_valid), 32'd0);
    check("stray_fe_drop", 32'(frame_dropped), 32'd0);
    $display("txn empty-read / stray frame_end");

    // Good frame
    cyc(1, 8'hAA, 0, 0, 0);
    check("good_lvl1", 32'(level), 32'd0);
    cyc(1, 8'hBB, 1, 0, 0);
    check("good_lvl2", 32'(level), 32'd2);
    cyc(0, 8'h00, 0, 0, 1);
    check("good_rd1", {23'd0, data_valid, last_out, data_out}, {23'd0, 1'b1, 1'b0, 8'hAA});
    cyc(0, 8'h00, 0, 0, 1);
    check("good_rd2", {23'd0, data_valid, last_out, data_out}, {23'd0, 1'b1, 1'b1, 8'hBB});
    check("good_empty", 32'(empty_flag), 32'd1);
    $display("txn good frame AA BB");

    // Bad frame after a committed one
    cyc(1, 8'h11, 1, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(1, 8'h33, 1, 1, 0);
    check("bad_pulse", 32'(frame_dropped), 32'd1);
    check("bad_cnt", 32'(drop_count), 32'd1);
    check("bad_level", 32'(level), 32'd1);
    cyc(0, 8'h00, 0, 0, 1);
    check("bad_pulse_end", 32'(frame_dropped), 32'd0);
    check("bad_rd", {23'd0, data_valid, last_out, data_out}, {23'd0, 1'b1, 1'b1, 8'h11});
    cyc(0, 8'h00, 0, 0, 1);
    check("bad_rd_empty", 32'(data_valid), 32'd0);
    $display("txn bad frame dropped");

    // Overflow: 20-byte frame into a 16-entry buffer
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'(i + 8'h40), (i == 19), 0, 0);
      if (i == 10) check("ovf_af_lo", 32'(almost_full_flag), 32'd0);
      if (i == 11) check("ovf_af_hi", 32'(almost_full_flag), 32'd1);
      if (i == 14) check("ovf_full15", 32'(full_flag), 32'd0);
      if (i == 15) check("ovf_full16", 32'(full_flag), 32'd1);
      if (i == 18) check("ovf_no_pulse", 32'(frame_dropped), 32'd0);
    end
    check("ovf_pulse", 32'(frame_dropped), 32'd1);
    check("ovf_level", 32'(level), 32'd0);
    check("ovf_empty", 32'(empty_flag), 32'd1);
    check("ovf_cnt", 32'(drop_count), 32'd1);
    check("ovf_full_clr", 32'(full_flag), 32'd0);
    $display("txn overflow frame dropped");

    // Wrap and concurrency: 40 five-byte frames with a read every cycle
    rx_q.delete();
    for (int f = 0; f < 40; f++)
      for (int b = 0; b < 5; b++) begin
        k = f * 5 + b;
        cyc(1, 8'(k), (b == 4), 0, 1);
      end
    repeat (10) cyc(0, 8'h00, 0, 0, 1);
    check("wrap_count", 32'(rx_q.size()), 32'd200);
    bad = 0;
    foreach (rx_q[i])
      if (rx_q[i] !== {((i % 5) == 4) ? 1'b1 : 1'b0, 8'(i)}) bad++;
    check("wrap_order", 32'(bad), 32'd0);
    check("wrap_cnt", 32'(drop_count), 32'd1);
    $display("txn wrap 40 frames");

    // Reset mid-frame
    cyc(1, 8'h01, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 0);
    cyc(1, 8'h03, 0, 0, 0);
    do_reset(1);
    check("mrst_empty", 32'(empty_flag), 32'd1);
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_pulse", 32'(frame_dropped), 32'd0);
    check("mrst_full", 32'(full_flag), 32'd0);
    cyc(1, 8'h5A, 0, 0, 0);
    cyc(1, 8'h5B, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 1);
    check("mrst_rd1", {23'd0, data_valid, last_out, data_out}, {23'd0, 1'b1, 1'b0, 8'h5A});
    cyc(0, 8'h00, 0, 0, 1);
    check("mrst_rd2", {23'd0, data_valid, last_out, data_out}, {23'd0, 1'b1, 1'b1, 8'h5B});
    cyc(0, 8'h00, 0, 0, 0);
    $display("txn reset mid-frame");

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
